// File: rtl/dest_reg_scoreboard_pkg.sv
// rtl/dest_reg_scoreboard_pkg.sv - shared pipeline constants and entry type for the destination scoreboard
package dest_reg_scoreboard_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b11
    } fwd_sel_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       ld;
    } entry_t;

endpackage

// File: rtl/dest_reg_scoreboard_src_match.sv
// rtl/dest_reg_scoreboard_src_match.sv - forward select and load-use hit for one source operand
module src_match
    import dest_reg_scoreboard_pkg::*;
(
    input  logic [4:0] src_i,
    input  logic       used_i,
    input  entry_t     ex_i,
    input  entry_t     mem_i,
    input  entry_t     wb_i,
    output logic [1:0] fwd_o,
    output logic       ld_hit_o
);

    always_comb begin
        fwd_o    = FWD_RF;
        ld_hit_o = 1'b0;
        if (used_i && (src_i != REG_ZERO)) begin
            // Youngest match wins; a load still in EX blocks older matches and forces a stall.
            if (ex_i.valid && (ex_i.dest == src_i)) begin
                if (ex_i.ld) begin
                    ld_hit_o = 1'b1;
                end else begin
                    fwd_o = FWD_EX;
                end
            end else if (mem_i.valid && (mem_i.dest == src_i)) begin
                fwd_o = FWD_MEM;
            end else if (wb_i.valid && (wb_i.dest == src_i)) begin
                fwd_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/dest_reg_scoreboard.sv
// rtl/dest_reg_scoreboard.sv - EX/MEM/WB destination tracking with load-use stall and forward selects
module dest_reg_scoreboard
    import dest_reg_scoreboard_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  dest_in,
    input  logic        dest_we,
    input  logic        dest_ld,
    input  logic        issue,
    input  logic        flush,
    input  logic [4:0]  rs_id,
    input  logic [4:0]  rt_id,
    input  logic        rs_used,
    input  logic        rt_used,
    output logic        stall,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [4:0]  wb_dest,
    output logic        wb_we,
    output logic [15:0] stall_cnt
);

    entry_t      ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  fwd_a_raw, fwd_b_raw;
    logic        hit_a, hit_b;

    src_match u_match_rs (
        .src_i    (rs_id),
        .used_i   (rs_used),
        .ex_i     (ex_q),
        .mem_i    (mem_q),
        .wb_i     (wb_q),
        .fwd_o    (fwd_a_raw),
        .ld_hit_o (hit_a)
    );

    src_match u_match_rt (
        .src_i    (rt_id),
        .used_i   (rt_used),
        .ex_i     (ex_q),
        .mem_i    (mem_q),
        .wb_i     (wb_q),
        .fwd_o    (fwd_b_raw),
        .ld_hit_o (hit_b)
    );

    // Outputs are forced quiet during reset so nothing references pre-reset entries.
    assign stall     = !rst && (hit_a || hit_b);
    assign fwd_a     = rst ? FWD_RF : fwd_a_raw;
    assign fwd_b     = rst ? FWD_RF : fwd_b_raw;
    assign wb_we     = !rst && wb_q.valid;
    assign wb_dest   = (!rst && wb_q.valid) ? wb_q.dest : REG_ZERO;
    assign stall_cnt = cnt_q;

    always_comb begin
        ex_d  = '0;
        mem_d = ex_q;
        wb_d  = mem_q;
        cnt_d = cnt_q;
        if (issue && !stall && !flush && dest_we && (dest_in != REG_ZERO)) begin
            ex_d.valid = 1'b1;
            ex_d.dest  = dest_in;
            ex_d.ld    = dest_ld;
        end
        if (stall && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_dest_reg_scoreboard.sv
// tb/tb_dest_reg_scoreboard.sv - randomized and directed self-checking bench for dest_reg_scoreboard
module tb_dest_reg_scoreboard;

    logic        clk = 1'b0;
    logic        rst, dest_we, dest_ld, issue, flush, rs_used, rt_used;
    logic [4:0]  dest_in, rs_id, rt_id;
    logic        stall, wb_we;
    logic [1:0]  fwd_a, fwd_b;
    logic [4:0]  wb_dest;
    logic [15:0] stall_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Reference: slot 0 = instruction one stage past ID, 1 = two, 2 = three; dest -1 means empty.
    int m_dest[3];
    bit m_ld[3];
    int m_cnt;

    logic [31:0] o_stall, o_fa, o_fb, o_cnt, o_wbwe, o_wbd;

    always #5 clk = ~clk;

    dest_reg_scoreboard #(.DEPTH(3)) dut (
        .clk(clk), .rst(rst), .dest_in(dest_in), .dest_we(dest_we), .dest_ld(dest_ld),
        .issue(issue), .flush(flush), .rs_id(rs_id), .rt_id(rt_id),
        .rs_used(rs_used), .rt_used(rt_used), .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .wb_dest(wb_dest), .wb_we(wb_we), .stall_cnt(stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_fwd(input int src, input bit used);
        if (rst || !used || src == 0) return 0;
        for (int age = 0; age < 3; age++) begin
            if (m_dest[age] == src) return (age == 0 && m_ld[0]) ? 0 : age + 1;
        end
        return 0;
    endfunction

    function automatic int exp_stall();
        if (rst || m_dest[0] < 0 || !m_ld[0]) return 0;
        return ((rs_used && int'(rs_id) == m_dest[0]) || (rt_used && int'(rt_id) == m_dest[0])) ? 1 : 0;
    endfunction

    task automatic cyc(input bit r, input bit is, input bit we, input bit ld, input int d,
                       input bit fl, input int rs, input bit ru, input int rt, input bit tu);
        int st;
        @(negedge clk);
        rst = r; issue = is; dest_we = we; dest_ld = ld; dest_in = 5'(d);
        flush = fl; rs_id = 5'(rs); rs_used = ru; rt_id = 5'(rt); rt_used = tu;
        #1;
        st = exp_stall();
        o_stall = 32'(stall); o_fa = 32'(fwd_a); o_fb = 32'(fwd_b);
        o_cnt = 32'(stall_cnt); o_wbwe = 32'(wb_we); o_wbd = 32'(wb_dest);
        check("stall", o_stall, st);
        check("fwd_a", o_fa, exp_fwd(rs, ru));
        check("fwd_b", o_fb, exp_fwd(rt, tu));
        check("stall_cnt", o_cnt, m_cnt);
        check("wb_we", o_wbwe, (!rst && m_dest[2] >= 0) ? 1 : 0);
        check("wb_dest", o_wbd, (!rst && m_dest[2] >= 0) ? m_dest[2] : 0);
        @(posedge clk);
        if (r) begin
            m_dest = '{-1, -1, -1};
            m_ld   = '{0, 0, 0};
            m_cnt  = 0;
        end else begin
            if (st == 1 && m_cnt < 65535) m_cnt++;
            m_dest[2] = m_dest[1]; m_ld[2] = m_ld[1];
            m_dest[1] = m_dest[0]; m_ld[1] = m_ld[0];
            if (is && st == 0 && !fl && we && d != 0) begin
                m_dest[0] = d; m_ld[0] = ld;
            end else begin
                m_dest[0] = -1; m_ld[0] = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        m_dest = '{-1, -1, -1};
        m_ld   = '{0, 0, 0};
        m_cnt  = 0;
        rst = 1'b1; issue = 0; dest_we = 0; dest_ld = 0; dest_in = 0;
        flush = 0; rs_id = 0; rt_id = 0; rs_used = 0; rt_used = 0;

        // Reset held two cycles while issuing dest 5
        cyc(1, 1, 1, 0, 5, 0, 5, 1, 5, 1);
        cyc(1, 1, 1, 0, 5, 0, 5, 1, 5, 1);
        cyc(0, 0, 0, 0, 0, 0, 5, 1, 0, 0);
        check("rst_wb_we", o_wbwe, 0);
        check("rst_stall", o_stall, 0);
        check("rst_cnt", o_cnt, 0);

        // Load-use on rs
        cyc(0, 1, 1, 1, 8, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 20, 0, 8, 1, 0, 0);
        check("lu_stall", o_stall, 1);
        cyc(0, 1, 1, 0, 20, 0, 8, 1, 0, 0);
        check("lu_stall_end", o_stall, 0);
        check("lu_fwd_a", o_fa, 2);
        check("lu_cnt", o_cnt, 1);
        idle(3);

        // ALU chain on rt
        cyc(0, 1, 1, 0, 3, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 3, 1); check("chain_ex", o_fb, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 3, 1); check("chain_mem", o_fb, 2);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 3, 1); check("chain_wb", o_fb, 3);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 3, 1); check("chain_done", o_fb, 0);

        // Youngest producer wins
        cyc(0, 1, 1, 0, 4, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 4, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 4, 1, 0, 0); check("prio_fwd_a", o_fa, 1);
        idle(3);

        // Register zero is never tracked
        cyc(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); check("r0_fwd_a", o_fa, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); check("r0_wb_we", o_wbwe, 0);

        // Flush coincident with load-use stall
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 1, 9, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 12, 1, 9, 1, 0, 0); check("fs_stall", o_stall, 1);
        cyc(0, 0, 0, 0, 0, 0, 9, 1, 0, 0);
        check("fs_fwd_mem", o_fa, 2);
        check("fs_cnt", o_cnt, 1);
        idle(3);

        // Reset mid-stall discards the load
        cyc(0, 1, 1, 1, 7, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 11, 0, 7, 1, 7, 1); check("rst_mid_stall", o_stall, 0);
        cyc(0, 0, 0, 0, 0, 0, 7, 1, 7, 1); check("rst_mid_fwd", o_fa, 0);

        // Randomized traffic over a small register range to provoke hazards
        for (int i = 0; i < 2000; i++) begin
            cyc(($urandom_range(0, 99) == 0), 1'($urandom), 1'($urandom_range(0, 3) != 0),
                1'($urandom), int'($urandom_range(0, 7)), ($urandom_range(0, 9) == 0),
                int'($urandom_range(0, 7)), 1'($urandom), int'($urandom_range(0, 7)), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
